// File: rtl/m_fmap_stream_buf.sv
// Feature-map ping buffer: captures one layer's output map into RAM,
// replays it as a continuous stream, flushes the consumer, then re-arms.
module m_fmap_stream_buf #(
   parameter int DATA_W  = 16,
   parameter int NUM_PIX = 7744,
   parameter int ADDR_W  = 13,
   parameter int TAIL    = 864
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              save_in,
   input  logic [DATA_W-1:0] map_in,
   input  logic              go,
   input  logic              ds_ready,
   output logic [DATA_W-1:0] map_out,
   output logic              start,
   output logic              load_done,
   output logic              busy,
   output logic              ovf
);

   localparam int TW = (TAIL > 1) ? $clog2(TAIL) : 1;
   localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NUM_PIX - 1);
   localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL - 1);

   typedef enum logic [2:0] {
      S_CAPTURE,
      S_FULL,
      S_STREAM,
      S_FLUSH,
      S_WAIT
   } state_t;

   state_t state;

   logic [DATA_W-1:0] ram [0:(2**ADDR_W)-1];
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] out_cnt;
   logic [TW-1:0]     tail_cnt;
   logic              wr_en;

   // Only strobes seen while capturing (and out of reset) land in RAM
   always_comb begin
      wr_en = rst_n && (state == S_CAPTURE) && save_in;
   end

   // RAM write port; contents deliberately survive reset
   always_ff @(posedge clk_in) begin
      if (wr_en) ram[wr_addr] <= map_in;
   end

   // Capture / replay / flush / wait sequencer with registered outputs;
   // rd_addr always runs one pixel ahead of the pixel on map_out
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state     <= S_CAPTURE;
         wr_addr   <= '0;
         rd_addr   <= '0;
         out_cnt   <= '0;
         tail_cnt  <= '0;
         map_out   <= '0;
         start     <= 1'b0;
         load_done <= 1'b0;
         busy      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (save_in && (state != S_CAPTURE)) ovf <= 1'b1;
         unique case (state)
            S_CAPTURE: begin
               if (save_in) begin
                  if (wr_addr == PIX_LAST) begin
                     state     <= S_FULL;
                     load_done <= 1'b1;
                  end else begin
                     wr_addr <= wr_addr + ADDR_W'(1);
                  end
               end
            end
            S_FULL: begin
               if (go) begin
                  state   <= S_STREAM;
                  start   <= 1'b1;
                  busy    <= 1'b1;
                  map_out <= ram[rd_addr];
                  rd_addr <= rd_addr + ADDR_W'(1);
                  out_cnt <= '0;
               end
            end
            S_STREAM: begin
               if (out_cnt == PIX_LAST) begin
                  state    <= S_FLUSH;
                  map_out  <= '0;
                  tail_cnt <= '0;
               end else begin
                  map_out <= ram[rd_addr];
                  rd_addr <= rd_addr + ADDR_W'(1);
                  out_cnt <= out_cnt + ADDR_W'(1);
               end
            end
            S_FLUSH: begin
               if (tail_cnt == TAIL_LAST) state <= S_WAIT;
               else tail_cnt <= tail_cnt + TW'(1);
            end
            S_WAIT: begin
               if (!ds_ready) begin
                  state     <= S_CAPTURE;
                  start     <= 1'b0;
                  busy      <= 1'b0;
                  load_done <= 1'b0;
                  wr_addr   <= '0;
                  rd_addr   <= '0;
               end
            end
            default: state <= S_CAPTURE;
         endcase
      end
   end

endmodule

// File: tb/tb_m_fmap_stream_buf.sv
// Randomized bench for m_fmap_stream_buf against a transaction-level
// model: captured pixel array, expected replay stream, sticky overflow.
module tb_m_fmap_stream_buf;

   localparam int DW = 16;
   localparam int NP = 4;
   localparam int AW = 2;
   localparam int TL = 3;

   logic          clk_in = 1'b0;
   logic          rst_n = 1'b0;
   logic          save_in = 1'b0;
   logic [DW-1:0] map_in = '0;
   logic          go = 1'b0;
   logic          ds_ready = 1'b1;
   logic [DW-1:0] map_out;
   logic          start;
   logic          load_done;
   logic          busy;
   logic          ovf;

   int            errs = 0;
   int            checks = 0;
   logic          ovf_exp = 1'b0;
   logic [DW-1:0] pix [NP];

   m_fmap_stream_buf #(
      .DATA_W(DW), .NUM_PIX(NP), .ADDR_W(AW), .TAIL(TL)
   ) dut (
      .clk_in(clk_in), .rst_n(rst_n), .save_in(save_in),
      .map_in(map_in), .go(go), .ds_ready(ds_ready),
      .map_out(map_out), .start(start), .load_done(load_done),
      .busy(busy), .ovf(ovf)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk_idle(input string tag, input logic ld);
      chk({tag, ".start"}, 32'(start), 32'd0);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".map_out"}, 32'(map_out), 32'd0);
      chk({tag, ".load_done"}, 32'(load_done), 32'(ld));
      chk({tag, ".ovf"}, 32'(ovf), 32'(ovf_exp));
   endtask

   task automatic new_pix();
      for (int i = 0; i < NP; i++) pix[i] = DW'($urandom);
   endtask

   // Strobe pix[] in with random gaps and stray go pulses
   task automatic capture(input bit force_gap);
      int gaps;
      for (int i = 0; i < NP; i++) begin
         gaps = $urandom_range(0, 2);
         if (force_gap && i == 2 && gaps == 0) gaps = 1;
         for (int g = 0; g < gaps; g++) begin
            save_in = 1'b0;
            go = 1'($urandom_range(0, 1));
            tick();
            chk_idle("cap_gap", 1'b0);
         end
         save_in = 1'b1;
         map_in = pix[i];
         go = (i == NP - 1) ? 1'b1 : 1'($urandom_range(0, 1));
         tick();
         chk_idle("cap_strobe", (i == NP - 1));
      end
      save_in = 1'b0;
      go = 1'b0;
      tick();
      chk_idle("full_idle", 1'b1);
   endtask

   task automatic replay(input int hold, input bit inj, input bit go_save);
      go = 1'b1;
      if (go_save) begin
         save_in = 1'b1;
         map_in = DW'($urandom);
      end
      tick();
      go = 1'b0;
      if (go_save) begin
         save_in = 1'b0;
         ovf_exp = 1'b1;
      end
      for (int k = 0; k < NP; k++) begin
         chk("stream.start", 32'(start), 32'd1);
         chk("stream.busy", 32'(busy), 32'd1);
         chk("stream.map_out", 32'(map_out), 32'(pix[k]));
         chk("stream.ovf", 32'(ovf), 32'(ovf_exp));
         ds_ready = 1'($urandom_range(0, 1));
         if (inj && k == 1) begin
            save_in = 1'b1;
            map_in = DW'($urandom);
         end
         tick();
         if (save_in) begin
            save_in = 1'b0;
            ovf_exp = 1'b1;
         end
      end
      for (int t = 0; t < TL; t++) begin
         chk("flush.start", 32'(start), 32'd1);
         chk("flush.map_out", 32'(map_out), 32'd0);
         chk("flush.busy", 32'(busy), 32'd1);
         ds_ready = 1'($urandom_range(0, 1));
         tick();
      end
      ds_ready = 1'b1;
      for (int h = 0; h < hold; h++) begin
         chk("wait.start", 32'(start), 32'd1);
         chk("wait.map_out", 32'(map_out), 32'd0);
         chk("wait.load_done", 32'(load_done), 32'd1);
         tick();
      end
      ds_ready = 1'b0;
      chk("wait_last.start", 32'(start), 32'd1);
      chk("wait_last.busy", 32'(busy), 32'd1);
      tick();
      ds_ready = 1'b1;
      chk_idle("rearm", 1'b0);
   endtask

   initial begin
      // Reset held with a strobe present: nothing may leak out
      rst_n = 1'b0;
      save_in = 1'b1;
      map_in = 16'h0055;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle("reset", 1'b0);
      end
      rst_n = 1'b1;
      save_in = 1'b0;
      tick();
      chk_idle("post_reset", 1'b0);

      // Fixed map with boundary values, long WAIT hold
      pix[0] = 16'd10;
      pix[1] = 16'hFFFD;
      pix[2] = 16'd7;
      pix[3] = 16'h7FFF;
      capture(1'b1);
      replay(10, 1'b0, 1'b0);

      // Fresh capture after re-arm, overflow injected mid-stream
      new_pix();
      capture(1'b0);
      replay(2, 1'b1, 1'b0);

      // Reset on the second STREAM cycle aborts the replay
      new_pix();
      capture(1'b0);
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("abort.k0", 32'(map_out), 32'(pix[0]));
      tick();
      chk("abort.k1", 32'(map_out), 32'(pix[1]));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      ovf_exp = 1'b0;
      chk_idle("abort", 1'b0);
      new_pix();
      capture(1'b0);
      replay(0, 1'b0, 1'b0);

      // Randomized map/hold/overflow mixes, incl. save+go in FULL
      for (int n = 0; n < 8; n++) begin
         new_pix();
         capture(1'($urandom_range(0, 1)));
         replay($urandom_range(0, 4), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
